// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader.
// - Stream, word and counter widths, default ROM depth.
// - FSM state encoding (3-bit).
package imem_loader_pkg;

  localparam int unsigned BYTE_W    = 8;    // stream data width, also checksum width
  localparam int unsigned INSTR_W   = 32;   // word / address width
  localparam int unsigned ROM_DEPTH = 256;  // max words loadable
  localparam int unsigned CNT_W     = 16;   // header word-count width

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR0 = 3'd1,
    ST_HDR1 = 3'd2,
    ST_DATA = 3'd3,
    ST_CSUM = 3'd4
  } state_e;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write bus of the loader.
// - s_valid/s_data/s_ready : byte stream (valid/ready)
// - wr_en/wr_addr/wr_data  : imem write port, one strobe per word
// Modports: master = loader side, slave = stream source / memory side.
import imem_loader_pkg::*;

interface imem_loader_if;
  logic               s_valid;
  logic [BYTE_W-1:0]  s_data;
  logic               s_ready;
  logic               wr_en;
  logic [INSTR_W-1:0] wr_addr;
  logic [INSTR_W-1:0] wr_data;

  modport master (
    input  s_valid, s_data,
    output s_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    output s_valid, s_data,
    input  s_ready, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/imem_loader_word_packer.sv
// Assembles four stream bytes into one little-endian 32-bit word.
// Ports:
// - clk, rstn : clock, async active-low reset
// - clr       : synchronous clear of the byte position and partial word
// - byte_vld  : byte_in is consumed this cycle
// - byte_in   : stream byte
// - word_vld  : registered, high for the cycle after the 4th byte
// - word_out  : completed word (first byte in bits 7:0), held until next word
import imem_loader_pkg::*;

module imem_word_packer (
  input  logic               clk,
  input  logic               rstn,
  input  logic               clr,
  input  logic               byte_vld,
  input  logic [BYTE_W-1:0]  byte_in,
  output logic               word_vld,
  output logic [INSTR_W-1:0] word_out
);

  logic [1:0]         cnt_q, cnt_d;
  logic [23:0]        shift_q, shift_d;   // three earlier bytes, oldest lowest
  logic               word_vld_q, word_vld_d;
  logic [INSTR_W-1:0] word_q, word_d;

  always_comb begin
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    word_d     = word_q;
    word_vld_d = 1'b0;
    if (clr) begin
      cnt_d   = '0;
      shift_d = '0;
    end else if (byte_vld) begin
      cnt_d   = cnt_q + 2'd1;
      shift_d = {byte_in, shift_q[23:8]};
      if (cnt_q == 2'd3) begin
        word_d     = {byte_in, shift_q};
        word_vld_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q      <= '0;
      shift_q    <= '0;
      word_q     <= '0;
      word_vld_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      word_q     <= word_d;
      word_vld_q <= word_vld_d;
    end
  end

  assign word_vld = word_vld_q;
  assign word_out = word_q;

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: receives a framed program over a byte stream
// and writes it word by word into imem at byte addresses 0, 4, 8, ...
// The CPU is held in reset while loading and released only after a load
// whose trailing XOR checksum matches.
// Frame: CNT_LO, CNT_HI (word count N), 4*N data bytes, CSUM.
// Ports:
// - clk, rstn : clock, async active-low reset
// - start     : one-cycle pulse, begins a load (ignored while busy)
// - bus       : stream input and imem write bus (master modport)
// - cpu_rstn  : active-low CPU reset, 1 only after a successful load
// - busy      : load in progress
// - done      : one-cycle pulse on a successful load
// - err       : sticky error (oversize or checksum), cleared by start
import imem_loader_pkg::*;

module imem_loader #(
  parameter int unsigned MAX_WORDS = ROM_DEPTH
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         start,
  imem_loader_if.master bus,
  output logic         cpu_rstn,
  output logic         busy,
  output logic         done,
  output logic         err
);

  state_e             state_q, state_d;
  logic [BYTE_W-1:0]  cnt_lo_q, cnt_lo_d;
  logic [CNT_W-1:0]   n_q, n_d;
  logic [CNT_W-1:0]   word_cnt_q, word_cnt_d;
  logic [1:0]         byte_cnt_q, byte_cnt_d;
  logic [BYTE_W-1:0]  csum_q, csum_d;
  logic [INSTR_W-1:0] wr_addr_q, wr_addr_d;
  logic               s_ready_q, s_ready_d;
  logic               cpu_rstn_q, cpu_rstn_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic accept;
  logic pk_clr;
  logic pk_vld;

  assign accept = bus.s_valid & s_ready_q;
  assign pk_clr = (state_q == ST_IDLE) & start;
  assign pk_vld = accept & (state_q == ST_DATA);

  always_comb begin
    state_d    = state_q;
    cnt_lo_d   = cnt_lo_q;
    n_d        = n_q;
    word_cnt_d = word_cnt_q;
    byte_cnt_d = byte_cnt_q;
    csum_d     = csum_q;
    wr_addr_d  = wr_addr_q;
    cpu_rstn_d = cpu_rstn_q;
    busy_d     = busy_q;
    err_d      = err_q;
    done_d     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          err_d      = 1'b0;
          cpu_rstn_d = 1'b0;
          busy_d     = 1'b1;
          word_cnt_d = '0;
          byte_cnt_d = '0;
          csum_d     = '0;
          state_d    = ST_HDR0;
        end
      end
      ST_HDR0: begin
        if (accept) begin
          cnt_lo_d = bus.s_data;
          state_d  = ST_HDR1;
        end
      end
      ST_HDR1: begin
        if (accept) begin
          n_d = {bus.s_data, cnt_lo_q};
          if (32'(n_d) > MAX_WORDS) begin
            err_d   = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
          end else if (n_d == '0) begin
            state_d = ST_CSUM;
          end else begin
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (accept) begin
          csum_d     = csum_q ^ bus.s_data;
          byte_cnt_d = byte_cnt_q + 2'd1;
          // Address is latched on the same edge the packer raises word_vld,
          // so wr_addr lines up with wr_en/wr_data without an extra stage.
          if (byte_cnt_q == 2'd3) begin
            wr_addr_d  = {{(INSTR_W-CNT_W-2){1'b0}}, word_cnt_q, 2'b00};
            word_cnt_d = word_cnt_q + 1'b1;
            if (word_cnt_q == n_q - 1'b1) state_d = ST_CSUM;
          end
        end
      end
      ST_CSUM: begin
        if (accept) begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
          if (bus.s_data == csum_q) begin
            done_d     = 1'b1;
            cpu_rstn_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    s_ready_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      cnt_lo_q   <= '0;
      n_q        <= '0;
      word_cnt_q <= '0;
      byte_cnt_q <= '0;
      csum_q     <= '0;
      wr_addr_q  <= '0;
      s_ready_q  <= 1'b0;
      cpu_rstn_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_lo_q   <= cnt_lo_d;
      n_q        <= n_d;
      word_cnt_q <= word_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      csum_q     <= csum_d;
      wr_addr_q  <= wr_addr_d;
      s_ready_q  <= s_ready_d;
      cpu_rstn_q <= cpu_rstn_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  imem_word_packer u_packer (
    .clk      (clk),
    .rstn     (rstn),
    .clr      (pk_clr),
    .byte_vld (pk_vld),
    .byte_in  (bus.s_data),
    .word_vld (bus.wr_en),
    .word_out (bus.wr_data)
  );

  assign bus.s_ready = s_ready_q;
  assign bus.wr_addr = wr_addr_q;
  assign cpu_rstn    = cpu_rstn_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;

endmodule
